// File: rtl/mealy_pkg.sv
// Shared types and constants for the overlapping "1011" serial sequence detector.
package mealy_pkg;

    // Each state is the longest prefix of the pattern matched so far.
    typedef enum logic [1:0] {
        S0 = 2'b00,  // nothing matched
        S1 = 2'b01,  // "1"
        S2 = 2'b10,  // "10"
        S3 = 2'b11   // "101"
    } state_t;

    localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/mealy.sv
// Overlapping "1011" detector as a Mealy FSM: y is high while in S3 with din=1,
// i.e. combinationally during the cycle the final '1' is on din.
module mealy
    import mealy_pkg::*;
(
    input  logic din,
    input  logic clk,
    input  logic rst,
    output logic y
);

    state_t state_reg;
    state_t state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S0;
        end else begin
            state_reg <= state_next;
        end
    end

    // state | din=0      | din=1
    // S0    | S0, y=0    | S1, y=0
    // S1    | S2, y=0    | S1, y=0
    // S2    | S0, y=0    | S3, y=0
    // S3    | S2, y=0    | S1, y=1  (trailing '1' reused as prefix "1")
    always_comb begin
        state_next = state_reg;
        y          = 1'b0;
        case (state_reg)
            S0: state_next = din ? S1 : S0;
            S1: state_next = din ? S1 : S2;
            S2: state_next = din ? S3 : S0;
            S3: begin
                state_next = din ? S1 : S2;
                y          = din;
            end
            default: state_next = S0;
        endcase
    end

    y_only_in_s3: assert property (@(posedge clk) disable iff (rst)
        y |-> (state_reg == S3 && din));

endmodule

// File: tb/tb_mealy.sv
// Bench for the "1011" detector: directed sequences with explicit detect positions,
// async reset checks, and random stream checked against a pattern-window model.
module tb_mealy;
    import mealy_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic din;
    logic y;

    int errors = 0;
    int checks = 0;
    bit hist[$];
    logic [3:0] pat;

    mealy dut (
        .din (din),
        .clk (clk),
        .rst (rst),
        .y   (y)
    );

    always #5 clk = ~clk;

    // Reference: detect when the last three consumed bits plus the present bit spell the pattern.
    function automatic logic model_y(input logic b);
        int n;
        n = hist.size();
        if (b !== 1'b1 || n < 3) return 1'b0;
        return ({hist[n-3], hist[n-2], hist[n-1], 1'b1} == pat);
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic consume(input logic b);
        @(posedge clk);
        #1;
        hist.push_back(b);
        if (hist.size() > 8) void'(hist.pop_front());
    endtask

    // Hold reset for two cycles with din toggling (including X); release just after an edge.
    task automatic do_reset();
        rst = 1'b1;
        hist.delete();
        for (int i = 0; i < 4; i++) begin
            din = (i == 2) ? 1'bx : ((i % 2) == 1);
            #2;
            check("rst_y", y, 1'b0);
            check("rst_state_s0", (dut.state_reg === S0), 1'b1);
            #3;
        end
        din = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_seq(input string tag, input string bits, input string det);
        logic b;
        logic e;
        for (int i = 0; i < bits.len(); i++) begin
            b = (bits.getc(i) == "1");
            e = (det.getc(i) == "1");
            din = b;
            #2;
            check($sformatf("%s_bit%0d", tag, i + 1), y, e);
            consume(b);
        end
    endtask

    initial begin
        pat = PATTERN;
        rst = 1'b1;
        din = 1'b0;
        #1;
        check("initial_reset_y", y, 1'b0);
        do_reset();

        run_seq("basic", "01011", "00001");

        do_reset();
        run_seq("long", "01011001011011", "00001000001001");

        do_reset();
        run_seq("chain", "1011011011", "0001001001");

        do_reset();
        run_seq("ones", "1111", "0000");

        do_reset();
        run_seq("miss1", "10011", "00000");

        do_reset();
        run_seq("s3_to_s2", "101011", "000001");

        // Async reset while y is high in S3.
        do_reset();
        run_seq("pre_rst", "101", "000");
        din = 1'b1;
        #2;
        check("mid_y_before_rst", y, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_y_after_rst", y, 1'b0);
        check("mid_state_s0", (dut.state_reg === S0), 1'b1);
        din = 1'b0;
        #2;
        rst = 1'b0;
        hist.delete();
        consume(1'b0);
        run_seq("post_rst", "1011", "0001");

        // Random stream with a bias toward the pattern, checked against the window model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic b;
            logic e;
            b = ($urandom_range(0, 9) < 6);
            din = b;
            #2;
            e = model_y(b);
            check($sformatf("rand%0d", i), y, e);
            consume(b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
